mips_rtype_pipe: RTL and testbench

- Sequential successor to the combinational mips_core R-type datapath.
- Contains a parametrised register file and a 3-stage pipeline: S1 decode/read, S2 execute, S3 writeback/report.
- Accepts one 32-bit MIPS R-type instruction per cycle through a valid/ready handshake.
- Emits each result, together with its destination register, through an output handshake. Forwarding keeps back-to-back dependent instructions correct.

---
 rtl/mips_pkg.sv | 94 +++++++++
 rtl/mips_alu.sv | 54 +++++
 rtl/mips_rtype_pipe.sv | 165 ++++++++++++++++
 tb/tb_mips_rtype_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared decode constants, instruction field positions and ALU op encoding
// for the R-type pipeline.
package mips_pkg;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;

    localparam int unsigned OPC_MSB   = 31;
    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_MSB = 10;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    typedef enum logic [3:0] {
        OpAdd,
        OpAddu,
        OpSub,
        OpSubu,
        OpAnd,
        OpOr,
        OpXor,
        OpNor,
        OpSlt,
        OpSltu,
        OpSll,
        OpSrl,
        OpSra
    } alu_op_t;

    typedef struct packed {
        logic    legal;
        logic    var_sh;
        alu_op_t op;
    } funct_dec_t;

    // Variable shifts share the ALU op of their immediate form; var_sh picks the amount source.
    function automatic funct_dec_t decode_funct(input logic [5:0] funct);
        funct_dec_t d;
        d.legal  = 1'b1;
        d.var_sh = 1'b0;
        d.op     = OpAdd;
        case (funct)
            FN_ADD:  d.op = OpAdd;
            FN_ADDU: d.op = OpAddu;
            FN_SUB:  d.op = OpSub;
            FN_SUBU: d.op = OpSubu;
            FN_AND:  d.op = OpAnd;
            FN_OR:   d.op = OpOr;
            FN_XOR:  d.op = OpXor;
            FN_NOR:  d.op = OpNor;
            FN_SLT:  d.op = OpSlt;
            FN_SLTU: d.op = OpSltu;
            FN_SLL:  d.op = OpSll;
            FN_SRL:  d.op = OpSrl;
            FN_SRA:  d.op = OpSra;
            FN_SLLV: begin
                d.op     = OpSll;
                d.var_sh = 1'b1;
            end
            FN_SRLV: begin
                d.op     = OpSrl;
                d.var_sh = 1'b1;
            end
            FN_SRAV: begin
                d.op     = OpSra;
                d.var_sh = 1'b1;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational R-type ALU: arithmetic, logic, compares and shifts of b by sh.
// ovf flags signed overflow for the trapping add/sub forms only.
module mips_alu
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SH_W   = $clog2(DATA_W)
) (
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SH_W-1:0]   sh,
    output logic [DATA_W-1:0] y,
    output logic              ovf
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              sum_ovf;
    logic              diff_ovf;

    assign sum      = a + b;
    assign diff     = a - b;
    assign sum_ovf  = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    assign diff_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            OpAdd: begin
                y   = sum;
                ovf = sum_ovf;
            end
            OpAddu: y = sum;
            OpSub: begin
                y   = diff;
                ovf = diff_ovf;
            end
            OpSubu: y = diff;
            OpAnd:  y = a & b;
            OpOr:   y = a | b;
            OpXor:  y = a ^ b;
            OpNor:  y = ~(a | b);
            OpSlt:  y[0] = $signed(a) < $signed(b);
            OpSltu: y[0] = a < b;
            OpSll:  y = b << sh;
            OpSrl:  y = b >> sh;
            OpSra:  y = $signed(b) >>> sh;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mips_rtype_pipe.sv
// Three-stage R-type pipeline (S1 decode/read, S2 execute, S3 writeback) with register file,
// forwarding and valid/ready handshakes. Define MIPS_OVF_TRAP_EN to trap signed add/sub overflow.
module mips_rtype_pipe
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned SH_W      = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction_set,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        out_rd,
    output logic              out_illegal,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned AW = $clog2(REG_COUNT);

    logic [DATA_W-1:0] regs_q [REG_COUNT];

    // S2 (execute) pipeline register
    logic              s2_valid_q;
    alu_op_t           s2_op_q;
    logic [DATA_W-1:0] s2_a_q;
    logic [DATA_W-1:0] s2_b_q;
    logic [SH_W-1:0]   s2_sh_q;
    logic [4:0]        s2_rd_q;
    logic              s2_illegal_q;

    // S3 (writeback/report) pipeline register
    logic              s3_valid_q;
    logic [DATA_W-1:0] s3_result_q;
    logic [4:0]        s3_rd_q;
    logic              s3_illegal_q;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [AW-1:0]     rs_idx;
    logic [AW-1:0]     rt_idx;
    funct_dec_t        dec;
    logic              s1_illegal;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [SH_W-1:0]   s1_sh;

    logic [DATA_W-1:0] alu_y;
    logic              alu_ovf;
    logic              ovf_trap;
    logic              pipe_en;
    logic              s2_wen;
    logic              s3_wen;
    logic              out_fire;

    assign opcode = instruction_set[OPC_MSB:OPC_LSB];
    assign funct  = instruction_set[FUNCT_MSB:FUNCT_LSB];
    assign shamt  = instruction_set[SHAMT_MSB:SHAMT_LSB];
    assign rs_idx = instruction_set[RS_LSB +: AW];
    assign rt_idx = instruction_set[RT_LSB +: AW];

    mips_alu #(
        .DATA_W (DATA_W),
        .SH_W   (SH_W)
    ) u_alu (
        .op  (s2_op_q),
        .a   (s2_a_q),
        .b   (s2_b_q),
        .sh  (s2_sh_q),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

`ifdef MIPS_OVF_TRAP_EN
    assign ovf_trap = alu_ovf;
`else
    logic unused_alu_ovf;
    assign unused_alu_ovf = alu_ovf;
    assign ovf_trap       = 1'b0;
`endif

    // The whole pipe advances together whenever the output slot is not blocked.
    assign in_ready = !(s3_valid_q && !out_ready);
    assign pipe_en  = in_ready;
    assign out_fire = s3_valid_q && out_ready;

    // Only stages that will actually commit a write are forwarding sources.
    assign s2_wen = s2_valid_q && !s2_illegal_q && !ovf_trap && (s2_rd_q[AW-1:0] != '0);
    assign s3_wen = s3_valid_q && !s3_illegal_q && (s3_rd_q[AW-1:0] != '0);

    function automatic logic [DATA_W-1:0] fwd_read(input logic [AW-1:0] idx);
        if (idx == '0) begin
            return '0;
        end else if (s2_wen && (s2_rd_q[AW-1:0] == idx)) begin
            return alu_y;
        end else if (s3_wen && (s3_rd_q[AW-1:0] == idx)) begin
            return s3_result_q;
        end
        return regs_q[idx];
    endfunction

    always_comb begin
        dec        = decode_funct(funct);
        s1_illegal = (opcode != '0) || !dec.legal;
        rs_val     = fwd_read(rs_idx);
        rt_val     = fwd_read(rt_idx);
        s1_sh      = dec.var_sh ? rs_val[SH_W-1:0] : SH_W'(shamt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            s2_op_q      <= OpAdd;
            s2_a_q       <= '0;
            s2_b_q       <= '0;
            s2_sh_q      <= '0;
            s2_rd_q      <= '0;
            s2_illegal_q <= 1'b0;
            s3_valid_q   <= 1'b0;
            s3_result_q  <= '0;
            s3_rd_q      <= '0;
            s3_illegal_q <= 1'b0;
        end else if (pipe_en) begin
            s2_valid_q <= in_valid;
            if (in_valid) begin
                s2_op_q      <= dec.op;
                s2_a_q       <= rs_val;
                s2_b_q       <= rt_val;
                s2_sh_q      <= s1_sh;
                s2_rd_q      <= instruction_set[RD_MSB:RD_LSB];
                s2_illegal_q <= s1_illegal;
            end
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                // An overflow trap keeps the wrapped sum visible; only decode errors zero it.
                s3_result_q  <= s2_illegal_q ? '0 : alu_y;
                s3_rd_q      <= s2_rd_q;
                s3_illegal_q <= s2_illegal_q || ovf_trap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else if (out_fire && s3_wen) begin
            regs_q[s3_rd_q[AW-1:0]] <= s3_result_q;
        end
    end

    assign result      = s3_result_q;
    assign out_rd      = s3_rd_q;
    assign out_illegal = s3_illegal_q;
    assign out_valid   = s3_valid_q;
    assign dbg_data    = regs_q[dbg_addr[AW-1:0]];

endmodule

// File: tb/tb_mips_rtype_pipe.sv
// Scoreboard bench for mips_rtype_pipe: an ISA-level register model predicts each result when
// the instruction is driven; the output monitor pops and compares in order.
module tb_mips_rtype_pipe;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction_set;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] tb_regs [32];
    int          n_tests;
    int          n_fail;
    int          n_out;
    int          n_out_base;
    logic [31:0] last_res;
    logic [4:0]  last_rd;
    logic        last_ill;

    mips_rtype_pipe u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instruction_set (instruction_set),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .result          (result),
        .out_rd          (out_rd),
        .out_illegal     (out_illegal),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh,
                                          input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) tb_regs[i] = 32'(i);
    endtask

    // Architectural (in-order) model of one instruction; updates tb_regs.
    task automatic model_exec(input logic [31:0] ins, output logic [31:0] res, output logic ill);
        logic [31:0] a, b, r;
        logic [4:0]  rd, sh;
        logic        ovf;
        a   = tb_regs[ins[25:21]];
        b   = tb_regs[ins[20:16]];
        rd  = ins[15:11];
        sh  = ins[10:6];
        ovf = 1'b0;
        ill = 1'b0;
        r   = 32'd0;
        case (ins[5:0])
            6'h20: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
            6'h21: r = a + b;
            6'h22: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
            6'h23: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B: r = (a < b) ? 32'd1 : 32'd0;
            6'h00: r = b << sh;
            6'h02: r = b >> sh;
            6'h03: r = $signed(b) >>> sh;
            6'h04: r = b << a[4:0];
            6'h06: r = b >> a[4:0];
            6'h07: r = $signed(b) >>> a[4:0];
            default: ill = 1'b1;
        endcase
        if (ins[31:26] != 6'd0) ill = 1'b1;
        if (ill) r = 32'd0;
`ifdef MIPS_OVF_TRAP_EN
        if (ovf) ill = 1'b1;
`endif
        if (!ill && rd != 5'd0) tb_regs[rd] = r;
        res = r;
    endtask

    task automatic push_exp(input logic [31:0] ins);
        exp_t e;
        model_exec(ins, e.res, e.ill);
        e.rd = ins[15:11];
        sb_q.push_back(e);
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] ins);
        int waited;
        push_exp(ins);
        instruction_set = ins;
        in_valid        = 1'b1;
        waited          = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_eq("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_check(input string tag, input int addr, input logic [31:0] exp);
        dbg_addr = 5'(addr);
        #1;
        check_eq(tag, 64'(dbg_data), 64'(exp));
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            last_res = result;
            last_rd  = out_rd;
            last_ill = out_illegal;
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_out", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("sb_result", 64'(result), 64'(mon_e.res));
                check_eq("sb_rd", 64'(out_rd), 64'(mon_e.rd));
                check_eq("sb_illegal", 64'(out_illegal), 64'(mon_e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        n_out           = 0;
        rst_n           = 1'b0;
        in_valid        = 1'b0;
        instruction_set = 32'd0;
        out_ready       = 1'b1;
        dbg_addr        = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_out_rd", 64'(out_rd), 64'd0);
        check_eq("rst_out_illegal", 64'(out_illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        dbg_check("rst_reg1", 1, 32'd1);
        dbg_check("rst_reg0", 0, 32'd0);

        // First instruction and its latency
        send(32'h00205020);
        @(negedge clk);
        check_eq("lat_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_eq("lat_cycle2", 64'(out_valid), 64'd1);
        drain();
        check_eq("add_res", 64'(last_res), 64'd1);
        check_eq("add_rd", 64'(last_rd), 64'd10);
        dbg_check("add_reg10", 10, 32'd1);

        // Back-to-back dependents
        send(32'h00215020);
        send(32'h014A5820);
        send(32'h01616022);
        drain();
        check_eq("fwd_sub_res", 64'(last_res), 64'd3);
        dbg_check("fwd_reg10", 10, 32'd2);
        dbg_check("fwd_reg11", 11, 32'd4);
        dbg_check("fwd_reg12", 12, 32'd3);

        // Shifts and compares with reg[9] = 0x80000000
        send(rtype(0, 1, 9, 31, 'h00));
        send(32'h00095103);
        drain();
        check_eq("sra_res", 64'(last_res), 64'hF8000000);
        dbg_check("sll_reg9", 9, 32'h80000000);
        send(32'h00095102);
        drain();
        check_eq("srl_res", 64'(last_res), 64'h08000000);
        send(rtype(1, 9, 13, 0, 'h07));
        drain();
        check_eq("srav_res", 64'(last_res), 64'hC0000000);
        send(rtype(9, 1, 10, 0, 'h2A));
        drain();
        check_eq("slt_res", 64'(last_res), 64'd1);
        send(rtype(9, 1, 10, 0, 'h2B));
        drain();
        check_eq("sltu_res", 64'(last_res), 64'd0);

        // Backpressure: two in the pipe, a third waiting at the input
        n_out_base = n_out;
        out_ready  = 1'b0;
        send(rtype(1, 1, 5, 0, 'h20));
        send(rtype(5, 1, 6, 0, 'h20));
        push_exp(rtype(6, 5, 7, 0, 'h22));
        instruction_set = rtype(6, 5, 7, 0, 'h22);
        in_valid        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_result_held", 64'(result), 64'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        check_eq("bp_out_count", 64'(n_out - n_out_base), 64'd3);
        dbg_check("bp_reg7", 7, 32'd1);

        // Illegal instructions and writes to $zero
        send(32'h20215020);
        drain();
        check_eq("ill_opc_flag", 64'(last_ill), 64'd1);
        check_eq("ill_opc_res", 64'(last_res), 64'd0);
        dbg_check("ill_opc_noreg", 10, tb_regs[10]);
        send(rtype(1, 1, 10, 0, 'h01));
        drain();
        check_eq("ill_fn_flag", 64'(last_ill), 64'd1);
        dbg_check("ill_fn_noreg", 10, tb_regs[10]);
        send(rtype(1, 1, 0, 0, 'h20));
        drain();
        check_eq("zero_res", 64'(last_res), 64'd2);
        check_eq("zero_rd", 64'(last_rd), 64'd0);
        dbg_check("zero_reg0", 0, 32'd0);

        // Signed overflow on add (0x7FFFFFFF + 1), with a forwarded operand
        send(rtype(9, 0, 11, 0, 'h27));
        send(rtype(11, 1, 12, 0, 'h20));
        drain();
        check_eq("ovf_res", 64'(last_res), 64'h80000000);
`ifdef MIPS_OVF_TRAP_EN
        check_eq("ovf_flag", 64'(last_ill), 64'd1);
        dbg_check("ovf_reg12", 12, 32'd3);
`else
        check_eq("ovf_flag", 64'(last_ill), 64'd0);
        dbg_check("ovf_reg12", 12, 32'h80000000);
`endif

        // Reset mid-stream discards in-flight work and restores registers
        out_ready = 1'b0;
        send(rtype(1, 1, 14, 0, 'h20));
        send(rtype(1, 1, 15, 0, 'h20));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_result", 64'(result), 64'd0);
        sb_q.delete();
        model_reset();
        dbg_check("midrst_reg14", 14, 32'd14);
        dbg_check("midrst_reg10", 10, 32'd10);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        dbg_check("midrst_reg15", 15, 32'd15);
        @(posedge clk);
        #1;
        send(rtype(1, 1, 10, 0, 'h20));
        drain();
        check_eq("postrst_res", 64'(last_res), 64'd2);
        dbg_check("postrst_reg10", 10, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
